// File: rtl/arrow_game_pkg.sv
// Shared types and constants for the arrowspace game core: FSM states,
// SPI opcode nibbles, default reply word and the LFSR step function.
package arrow_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_MISS,
    ST_NEXT,
    ST_GAME_OVER,
    ST_WIN
  } state_t;

  localparam logic [3:0]  OP_LEVEL      = 4'h1;
  localparam logic [3:0]  OP_MATCH      = 4'h2;
  localparam logic [3:0]  OP_SCORE      = 4'h3;
  localparam logic [23:0] REPLY_DEFAULT = 24'hDDDDDD;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/arrow_lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the
// all-zero lock-up state forever.
module arrow_lfsr16
  import arrow_game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value <= LFSR_SEED;
    else       value <= lfsr_step(value);
  end

endmodule

// File: rtl/arrow_game_core.sv
// Arrowspace game core: random key sequences, per-level countdown, lives,
// level and SPI status reply. Optional score register: ARROW_SCORE_EN.
module arrow_game_core
  import arrow_game_pkg::*;
#(
  parameter int          KEY_W      = 4,
  parameter int          SEQ_LEN    = 4,
  parameter int          LEVEL_W    = 2,
  parameter int          LIVES      = 7,
  parameter int          TIMER_W    = 28,
  parameter int unsigned BASE_TICKS = 32'd268435455,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_code,
  input  logic [7:0]         opcode,
  output logic [23:0]        reply,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         lives,
  output logic [15:0]        key_seq,
  output logic               game_over,
  output logic               win,
  output logic               match_pulse
);

  localparam int                 SEQ_BITS   = SEQ_LEN * KEY_W;
  localparam logic [15:0]        SEQ_MASK   = 16'((33'd1 << SEQ_BITS) - 33'd1);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL  = '1;
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [3:0]         LAST_INDEX = 4'(SEQ_LEN - 1);

  state_t               state, state_nxt;
  logic [LEVEL_W-1:0]   level_nxt;
  logic [2:0]           lives_nxt;
  logic [15:0]          key_seq_nxt;
  logic [3:0]           index, index_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 match_nxt;
  logic [15:0]          lfsr;
  logic [KEY_W-1:0]     cur_key;
  logic                 key_hit, start_game;
  logic                 op_match, op_match_q, match_sticky;

  arrow_lfsr16 #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  assign cur_key    = key_seq[int'(index)*KEY_W +: KEY_W];
  assign key_hit    = (state == ST_PLAY) && key_valid && (key_code == cur_key);
  assign start_game = start && (state == ST_IDLE || state == ST_GAME_OVER || state == ST_WIN);
  assign game_over  = (state == ST_GAME_OVER);
  assign win        = (state == ST_WIN);

  always_comb begin
    state_nxt   = state;
    level_nxt   = level;
    lives_nxt   = lives;
    key_seq_nxt = key_seq;
    index_nxt   = index;
    timer_nxt   = timer;
    match_nxt   = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER, ST_WIN: begin
        if (start_game) begin
          level_nxt = '0;
          lives_nxt = LIVES_INIT;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        key_seq_nxt = lfsr & SEQ_MASK;
        index_nxt   = '0;
        timer_nxt   = TIMER_W'(BASE_TICKS >> level);
        state_nxt   = ST_PLAY;
      end
      ST_PLAY: begin
        if (timer != '0) timer_nxt = timer - TIMER_W'(1);
        if (key_hit) begin
          match_nxt = 1'b1;
          index_nxt = index + 4'd1;
        end
        // A completing key beats a simultaneous timeout
        if (key_hit && index == LAST_INDEX)     state_nxt = ST_NEXT;
        else if (key_valid || timer == '0)      state_nxt = key_hit ? ST_PLAY : ST_MISS;
      end
      ST_MISS: begin
        if (lives != 3'd0) lives_nxt = lives - 3'd1;
        state_nxt = (lives <= 3'd1) ? ST_GAME_OVER : ST_LOAD;
      end
      ST_NEXT: begin
        if (level == MAX_LEVEL) begin
          state_nxt = ST_WIN;
        end else begin
          level_nxt = level + LEVEL_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      level       <= '0;
      lives       <= LIVES_INIT;
      key_seq     <= '0;
      index       <= '0;
      timer       <= '0;
      match_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      lives       <= lives_nxt;
      key_seq     <= key_seq_nxt;
      index       <= index_nxt;
      timer       <= timer_nxt;
      match_pulse <= match_nxt;
    end
  end

  // Sticky match flag survives until the reader moves off the match opcode
  assign op_match = (opcode[7:4] == OP_MATCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_match_q   <= 1'b0;
      match_sticky <= 1'b0;
    end else begin
      op_match_q <= op_match;
      if (match_pulse)                match_sticky <= 1'b1;
      else if (op_match_q && !op_match) match_sticky <= 1'b0;
    end
  end

`ifdef ARROW_SCORE_EN
  logic [15:0] score, score_nxt;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    score_nxt = score;
    if (start_game)             score_nxt = '0;
    else if (key_hit)           score_nxt = sat_add16(score, 16'(level) + 16'd1);
    else if (state == ST_NEXT)  score_nxt = sat_add16(score, 16'(timer >> (TIMER_W - 8)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) score <= '0;
    else       score <= score_nxt;
  end
`endif

  always_comb begin
    reply = REPLY_DEFAULT;
    case (opcode[7:4])
      OP_LEVEL: reply = {game_over, lives, 4'(level), key_seq};
      OP_MATCH: reply = {match_sticky, win, 2'b00, index, 16'(timer >> (TIMER_W - 16))};
`ifdef ARROW_SCORE_EN
      OP_SCORE: reply = {8'h00, score};
`endif
      default:  reply = REPLY_DEFAULT;
    endcase
  end

endmodule

// File: tb/tb_arrow_game_core.sv
// Directed self-checking bench for arrow_game_core with a short countdown
// (BASE_TICKS=64, TIMER_W=16) so the timer is visible in the reply word.
module tb_arrow_game_core;

  localparam int KEY_W   = 4;
  localparam int SEQ_LEN = 4;
  localparam int LEVEL_W = 2;
  localparam int TIMER_W = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               key_valid = 1'b0;
  logic [KEY_W-1:0]   key_code = '0;
  logic [7:0]         opcode = 8'h10;
  logic [23:0]        reply;
  logic [LEVEL_W-1:0] level;
  logic [2:0]         lives;
  logic [15:0]        key_seq;
  logic               game_over, win, match_pulse;

  arrow_game_core #(
    .KEY_W(KEY_W), .SEQ_LEN(SEQ_LEN), .LEVEL_W(LEVEL_W), .LIVES(7),
    .TIMER_W(TIMER_W), .BASE_TICKS(32'd64), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key_valid(key_valid),
    .key_code(key_code), .opcode(opcode), .reply(reply), .level(level),
    .lives(lives), .key_seq(key_seq), .game_over(game_over), .win(win),
    .match_pulse(match_pulse)
  );

  always #5 clk = ~clk;

  // Reference LFSR written bit by bit from the polynomial x^16+x^14+x^13+x^11+1
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[0], m_lfsr[15], m_lfsr[14] ^ m_lfsr[0], m_lfsr[13] ^ m_lfsr[0],
                    m_lfsr[12], m_lfsr[11] ^ m_lfsr[0], m_lfsr[10:1]};
  end

  typedef struct {
    logic [7:0]  op;
    logic [23:0] exp;
    string       name;
  } vec_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] exp_seq;
  logic [23:0] r;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic peek(input logic [7:0] op, output logic [23:0] val);
    logic [7:0] saved;
    saved = opcode;
    opcode = op;
    #1;
    val = reply;
    opcode = saved;
  endtask

  // Called on the negedge while the core sits in LOAD
  task automatic load_after();
    exp_seq = m_lfsr;
    step();
    check("key_seq_load", 32'(key_seq), 32'(exp_seq));
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    load_after();
  endtask

  task automatic press(input logic [3:0] k, input logic exp_match);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    check("match_pulse", 32'(match_pulse), 32'(exp_match));
  endtask

  task automatic play_level();
    for (int i = 0; i < SEQ_LEN; i++) press(exp_seq[i*4 +: 4], 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    peek(8'h10, r);
    check("reset_reply", 32'(r), 32'h700000);
    check("reset_level", 32'(level), 32'd0);
    check("reset_lives", 32'(lives), 32'd7);
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'h10, 24'h700000, "op10_idle"};
    vecs[1] = '{8'h1F, 24'h700000, "op1f_idle"};
    vecs[2] = '{8'h20, 24'h000000, "op20_idle"};
    vecs[3] = '{8'h2A, 24'h000000, "op2a_idle"};
    vecs[4] = '{8'h55, 24'hDDDDDD, "op55_idle"};
    vecs[5] = '{8'h00, 24'hDDDDDD, "op00_idle"};
    vecs[6] = '{8'hFF, 24'hDDDDDD, "opff_idle"};

    #1 reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_lives", 32'(lives), 32'd7);
    check("rst_level", 32'(level), 32'd0);
    check("rst_key_seq", 32'(key_seq), 32'd0);
    check("rst_flags", 32'({game_over, win, match_pulse}), 32'd0);
    for (int i = 0; i < 7; i++) begin
      opcode = vecs[i].op;
      #1;
      check(vecs[i].name, 32'(reply), 32'(vecs[i].exp));
    end
    opcode = 8'h10;
    press(4'h0, 1'b0);
    check("idle_key_ignored", 32'(lives), 32'd7);

    // Full level clear, then level 1 reload with half the time
    do_start();
    peek(8'h20, r);
    check("timer_l0", 32'(r), 32'h000040);
    play_level();
    step();
    check("level_after_clear", 32'(level), 32'd1);
    load_after();
    peek(8'h20, r);
    check("l1_sticky_timer", 32'(r), 32'h800020);
    opcode = 8'h20;
    step();
    opcode = 8'h10;
    step();
    peek(8'h20, r);
    check("sticky_cleared", 32'(r), 32'h00001E);

    // Wrong key at index 1
    pulse_reset();
    do_start();
    press(exp_seq[3:0], 1'b1);
    press(exp_seq[7:4] ^ 4'h1, 1'b0);
    check("miss_lives_hold", 32'(lives), 32'd7);
    step();
    check("miss_lives", 32'(lives), 32'd6);
    check("miss_level", 32'(level), 32'd0);
    load_after();
    peek(8'h20, r);
    check("miss_index_reset", 32'(r), 32'h800040);

    // Seven timeouts drain all lives
    pulse_reset();
    do_start();
    for (int rnd = 1; rnd <= 7; rnd++) begin
      int cnt;
      logic [2:0] prev;
      cnt = 0;
      prev = lives;
      while (lives == prev && cnt < 200) begin
        step();
        cnt++;
      end
      check("timeout_cycles", 32'(cnt), 32'd66);
      check("timeout_lives", 32'(lives), 32'(7 - rnd));
      if (rnd < 7) load_after();
    end
    check("game_over", 32'(game_over), 32'd1);
    peek(8'h10, r);
    check("game_over_reply", 32'(r), 32'h800000 | 32'(exp_seq));
    press(exp_seq[3:0], 1'b0);
    check("go_key_lives", 32'(lives), 32'd0);
    check("go_stays", 32'(game_over), 32'd1);

    // Clear all four levels
    do_start();
    check("restart_lives", 32'(lives), 32'd7);
    check("restart_go", 32'(game_over), 32'd0);
    for (int lv = 0; lv < 4; lv++) begin
      check("win_path_level", 32'(level), 32'(lv));
      peek(8'h20, r);
      check("win_path_timer", 32'(r[15:0]), 32'(64 >> lv));
      play_level();
      step();
      if (lv < 3) load_after();
    end
    check("win_flag", 32'(win), 32'd1);
    check("win_level", 32'(level), 32'd3);
    press(4'h0, 1'b0);
    check("win_stays", 32'(win), 32'd1);
    do_start();
    check("after_win_level", 32'(level), 32'd0);
    check("after_win_lives", 32'(lives), 32'd7);
    check("after_win_flag", 32'(win), 32'd0);

    // Last key lands on the cycle the timer reaches zero
    for (int i = 0; i < 3; i++) press(exp_seq[i*4 +: 4], 1'b1);
    repeat (61) step();
    peek(8'h20, r);
    check("timer_zero", 32'(r[15:0]), 32'd0);
    press(exp_seq[15:12], 1'b1);
    step();
    check("tie_level", 32'(level), 32'd1);
    check("tie_lives", 32'(lives), 32'd7);
    peek(8'h55, r);
    check("op55_play", 32'(r), 32'hDDDDDD);
`ifndef ARROW_SCORE_EN
    peek(8'h30, r);
    check("op30_noscore", 32'(r), 32'hDDDDDD);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arrow_game_core.md
Name: arrow_game_core

Overview:
Parametrised successor of the single-player arrowspace game logic. Generates a per-level random key sequence, matches decoded controller key strobes against it, and applies a per-level countdown that shortens as levels rise. Tracks lives, level and game state, and serves a 24-bit status reply selected by the SPI opcode. Sits between the controller decoder and the SPI slave.

Parameters:
KEY_W, 4, width of one key code
SEQ_LEN, 4, keys per level sequence (SEQ_LEN*KEY_W <= 16)
LEVEL_W, 2, level counter width (<= 4); MAX_LEVEL = 2**LEVEL_W - 1
LIVES, 7, initial lives (fits 3 bits)
TIMER_W, 28, countdown width
BASE_TICKS, 2**28-1, level-0 time limit in clk cycles; level L limit = BASE_TICKS >> L
LFSR_SEED, 16'hACE1, nonzero LFSR reset value

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
start  in  1  pulse; begins game from IDLE/GAME_OVER/WIN
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  KEY_W  decoded key pressed
opcode  in  8  active SPI opcode
reply  out  24  status word for SPI
level  out  LEVEL_W  current level
lives  out  3  remaining lives
key_seq  out  16  current sequence, zero-extended, key 0 in LSBs
game_over  out  1  high in GAME_OVER
win  out  1  high in WIN
match_pulse  out  1  one-cycle pulse on each correct key

Behaviour:
- Reset: state IDLE, level 0, lives LIVES, key_seq 0, index 0, timer 0, match_pulse 0, game_over 0, win 0, LFSR = LFSR_SEED.
- LFSR: 16-bit Galois (taps 16,14,13,11), advances every cycle in all states; never zero.
- States: IDLE, LOAD, PLAY, MISS, NEXT, GAME_OVER, WIN.
- IDLE/GAME_OVER/WIN + start: level 0, lives LIVES, flags cleared -> LOAD.
- LOAD (1 cycle): key_seq <= low SEQ_LEN*KEY_W bits of LFSR; index 0; timer <= BASE_TICKS >> level -> PLAY.
- PLAY: timer decrements by 1 per cycle. On key_valid: key_code == key[index] -> match_pulse next cycle, index+1; if index was SEQ_LEN-1 -> NEXT. Mismatch -> MISS.
- Timer reaches 0 in PLAY without a completing key -> MISS. Completing key and timeout in the same cycle: the key wins (-> NEXT).
- key_valid outside PLAY: ignored.
- MISS (1 cycle): lives-1; if result 0 -> GAME_OVER, else -> LOAD (same level, new sequence).
- NEXT (1 cycle): level == MAX_LEVEL -> WIN; else level+1 -> LOAD.
- Lives never underflow; level never wraps.
- reply (combinational, casez on opcode):
  0001zzzz: {game_over, lives[2:0], 4'(level), key_seq}
  0010zzzz: {match_pulse_sticky, win, 2'b0, 4'(index), 16'(timer >> (TIMER_W-16))}; sticky set by match_pulse, cleared on this opcode falling away.
  default: 24'hDDDDDD.
- reset mid-game: immediate return to reset values; no reply glitch beyond reset values.

Optional Feature:
ARROW_SCORE_EN: defined -> 16-bit saturating score, +(level+1) per correct key, +timer>>(TIMER_W-8) bonus on NEXT, cleared on start; opcode 0011zzzz replies {8'b0, score}. Undefined -> no score register; 0011zzzz returns 24'hDDDDDD.

Decomposition:
- Package arrow_game_pkg: state enum, opcode constants (OP_LEVEL=4'h1, OP_MATCH=4'h2, OP_SCORE=4'h3), REPLY_DEFAULT=24'hDDDDDD.
- Sub-module arrow_lfsr16 (seeded free-running LFSR).

Test Plan:
- KEY_W=4, SEQ_LEN=4, BASE_TICKS=64; reset -> lives=7, level=0, reply(0x10)=0x700000|key_seq=0, state IDLE.
- start, press the 4 keys of key_seq -> 4 match_pulses, level=1, new key_seq, timer reloaded to 32.
- start, wrong key on index 1 -> lives=6, level unchanged, key_seq regenerated, index 0.
- start, no keys for 64 cycles -> MISS, lives 7->6; repeat 7 times -> game_over=1, reply bit23=1, further keys ignored.
- Complete level MAX_LEVEL=3 -> win=1; start -> level 0, lives 7, win 0.
- Last key on the same cycle timer hits 0 -> level advances, lives unchanged; opcode 0x55 -> 0xDDDDDD.
